mem_access_stage: RTL and testbench
===================================

// Module: mem_access_stage
// PURPOSE
//  Stage directly downstream of the ALU. Accepts one ALU result per handshake with its opcode, store data and destination register.
//  Runs LW/SW against a single-port data memory (req/ack, variable latency). Forwards R-type and load results to register-file writeback.
//  Multi-cycle FSM with a bounded wait; misaligned addresses and memory timeouts raise err.
// PARAMETERS
//  ADDR_W   10   word-address width driven on mem_addr (byte address bits [ADDR_W+1:2])
//  TIMEOUT  16   max cycles spent in MEM_WAIT without mem_ack before abort (>=1)
// PORTS
//  clk         in   1   single clock, all state on rising edge
//  rst         in   1   asynchronous, active-high reset
//  in_valid    in   1   upstream ALU result valid
//  in_ready    out  1   stage can accept this cycle
//  opcode      in   6   instruction opcode paired with result
//  alu_result  in   32  ALU result (byte address for LW/SW)
//  alu_rw      in   1   ALU write-enable for R-type
//  store_data  in   32  Rt value for SW
//  dest_reg    in   5   destination register (rd for R-type, rt for LW)
//  mem_req     out  1   memory request, held until ack/timeout
//  mem_we      out  1   1 = write (SW), 0 = read (LW)
//  mem_addr    out  ADDR_W  word address
//  mem_wdata   out  32  store data
//  mem_ack     in   1   memory completion, 1-cycle pulse
//  mem_rdata   in   32  load data, valid with mem_ack
//  wb_valid    out  1   writeback record valid
//  wb_ready    in   1   register file accepts record
//  wb_reg      out  5   writeback register index
//  wb_data     out  32  writeback value
//  err         out  1   1-cycle pulse: misaligned LW/SW or memory timeout
// BEHAVIOUR
//  Reset: state=IDLE; in_ready=1 after reset release; mem_req, mem_we, mem_addr, mem_wdata, wb_valid, wb_reg, wb_data, err, and the timer all =0.
//   Reset mid-transaction drops mem_req and wb_valid immediately, with no err.
//  States: IDLE, MEM_WAIT, WB_HOLD. in_ready = (state==IDLE). Accept = in_valid & in_ready.
//  IDLE on accept:
//   - opcode 000000 & alu_rw & dest_reg!=0 -> latch wb_reg/wb_data=alu_result, go WB_HOLD.
//   - 100011 (LW) or 101011 (SW), alu_result[1:0]==0 -> latch addr/wdata/we, mem_req=1, go MEM_WAIT, timer=0.
//   - LW/SW with alu_result[1:0]!=0 -> err=1 next cycle, no memory access, stay IDLE.
//   - anything else (R-type with alu_rw=0 or dest 0, BEQ 000100, BNE 000101, unknown) -> consumed, no effect, stay IDLE.
//  MEM_WAIT: mem_req, mem_we, mem_addr and mem_wdata are held stable. The timer increments each cycle without ack.
//   - mem_ack & LW: wb_data=mem_rdata, wb_reg=dest_reg. mem_req=0 next cycle. If dest_reg!=0 go WB_HOLD, else IDLE.
//   - mem_ack & SW: mem_req=0, go IDLE (no writeback).
//   - timer reaches TIMEOUT-1 with no ack: mem_req=0, err pulse, go IDLE. If ack and timeout coincide, ack wins.
//   - mem_ack outside MEM_WAIT is ignored.
//  WB_HOLD: wb_valid=1; wb_reg and wb_data are stable until wb_ready. On wb_valid&wb_ready -> wb_valid=0, go IDLE.
//  Latency:
//   - R-type: accept at cycle N -> wb_valid at N+1.
//   - LW: accept at N -> mem_req at N+1. mem_ack at M -> wb_valid at M+1.
//   - Best case back-to-back R-type throughput is one instruction per 2 cycles.
//  mem_addr = latched alu_result[ADDR_W+1:2]; higher address bits are ignored (no wrap check).
// TESTING
//  1 R-type ADD: opcode=0, alu_rw=1, dest=5, result=0x0000_0007 -> wb_valid next cycle with wb_reg=5, wb_data=7.
//     Hold wb_ready=0 for 3 cycles -> wb_reg/wb_data stable and in_ready=0 throughout.
//  2 LW addr 0x10, dest=8, ack after 4 cycles with rdata=0xDEAD_BEEF:
//     mem_req=1 and mem_we=0 with mem_addr=4 for 4 cycles, then wb_data=0xDEADBEEF, wb_reg=8.
//  3 SW addr 0x24, store_data=0x1234_5678, ack after 1 cycle:
//     mem_we=1, mem_addr=9, mem_wdata=0x12345678; returns to IDLE, wb_valid never asserted.
//  4 LW addr 0x13 -> err pulse 1 cycle, mem_req stays 0.
//     LW addr 0x40 with no ack, TIMEOUT=16 -> mem_req drops after 16 cycles and err pulses once.
//  5 BEQ/BNE and R-type with dest=0 -> accepted, no mem_req, no wb_valid, in_ready stays 1.
//  6 Reset asserted mid-MEM_WAIT and mid-WB_HOLD -> mem_req/wb_valid drop without waiting for clk and err stays 0.
//     Late mem_ack after reset release is ignored.

Source files
------------

// File: rtl/mem_access_stage.sv
// Memory-access stage behind the ALU: runs LW/SW against a req/ack data memory
// and hands R-type and load results to register-file writeback.
module mem_access_stage #(
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        opcode,
  input  logic [31:0]       alu_result,
  input  logic              alu_rw,
  input  logic [31:0]       store_data,
  input  logic [4:0]        dest_reg,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [4:0]        wb_reg,
  output logic [31:0]       wb_data,
  output logic              err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_WAIT = 2'd1,
    WB_HOLD  = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [TW-1:0] timer_p0;
  logic [4:0]    ld_dest_p0;

  logic accept;
  logic is_mem;
  logic aligned;
  logic rtype_wb;
  logic timeout_hit;

  assign accept   = in_valid & in_ready;
  assign is_mem   = (opcode == OP_LW) || (opcode == OP_SW);
  assign aligned  = (alu_result[1:0] == 2'b00);
  assign rtype_wb = (opcode == OP_RTYPE) && alu_rw && (dest_reg != 5'd0);
  // An ack arriving in the last allowed cycle still completes the access.
  assign timeout_hit = (state == MEM_WAIT) && !mem_ack &&
                       (timer_p0 == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (rtype_wb) begin
            state_nxt = WB_HOLD;
          end else if (is_mem && aligned) begin
            state_nxt = MEM_WAIT;
          end
        end
      end
      MEM_WAIT: begin
        if (mem_ack) begin
          // Loads into r0 complete the access but produce no writeback.
          state_nxt = (!mem_we && (ld_dest_p0 != 5'd0)) ? WB_HOLD : IDLE;
        end else if (timeout_hit) begin
          state_nxt = IDLE;
        end
      end
      WB_HOLD: begin
        if (wb_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decode straight from state so reset removes them at once.
  always_comb begin
    in_ready = (state == IDLE);
    mem_req  = (state == MEM_WAIT);
    wb_valid = (state == WB_HOLD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err        <= 1'b0;
      timer_p0   <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      ld_dest_p0 <= '0;
      wb_reg     <= '0;
      wb_data    <= '0;
    end else begin
      err <= (accept && is_mem && !aligned) || timeout_hit;

      if ((state == MEM_WAIT) && (state_nxt == MEM_WAIT)) begin
        timer_p0 <= timer_p0 + TW'(1);
      end else begin
        timer_p0 <= '0;
      end

      if (accept && rtype_wb) begin
        wb_reg  <= dest_reg;
        wb_data <= alu_result;
      end

      if (accept && is_mem && aligned) begin
        mem_we     <= (opcode == OP_SW);
        mem_addr   <= alu_result[ADDR_W+1:2];
        mem_wdata  <= store_data;
        ld_dest_p0 <= dest_reg;
      end

      if ((state == MEM_WAIT) && mem_ack && !mem_we) begin
        wb_reg  <= ld_dest_p0;
        wb_data <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed table, randomized vectors scored by a
// behavioural model, and hand-written reset/throughput sequences.
module tb_mem_access_stage;

  localparam int ADDR_W  = 10;
  localparam int TIMEOUT = 16;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [5:0]        opcode = '0;
  logic [31:0]       alu_result = '0;
  logic              alu_rw = 1'b0;
  logic [31:0]       store_data = '0;
  logic [4:0]        dest_reg = '0;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ack = 1'b0;
  logic [31:0]       mem_rdata = '0;
  logic              wb_valid;
  logic              wb_ready = 1'b0;
  logic [4:0]        wb_reg;
  logic [31:0]       wb_data;
  logic              err;

  int checks   = 0;
  int failures = 0;

  mem_access_stage #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .alu_result(alu_result), .alu_rw(alu_rw),
    .store_data(store_data), .dest_reg(dest_reg),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_reg(wb_reg),
    .wb_data(wb_data), .err(err)
  );

  always #5 clk = ~clk;

  // ack: cycle of mem_req (1-based) in which mem_ack is pulsed, 0 = never.
  // e_mem: expected number of mem_req cycles.
  typedef struct {
    logic [5:0]  op;
    logic [31:0] res;
    logic        rw;
    logic [31:0] sd;
    logic [4:0]  dest;
    int          ack;
    logic [31:0] rdata;
    int          stall;
    bit          e_err;
    int          e_mem;
    bit          e_we;
    logic [9:0]  e_addr;
    bit          e_wb;
    logic [4:0]  e_reg;
    logic [31:0] e_data;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t model(input vec_t v);
    vec_t r;
    r = v;
    r.e_err = 1'b0; r.e_mem = 0; r.e_we = 1'b0; r.e_addr = '0;
    r.e_wb = 1'b0; r.e_reg = '0; r.e_data = '0;
    if (v.op == 6'd0) begin
      if (v.rw && v.dest != 5'd0) begin
        r.e_wb = 1'b1; r.e_reg = v.dest; r.e_data = v.res;
      end
    end else if (v.op == OP_LW || v.op == OP_SW) begin
      if (v.res % 4 != 0) begin
        r.e_err = 1'b1;
      end else begin
        r.e_we   = (v.op == OP_SW);
        r.e_addr = 10'((v.res / 4) % 1024);
        if (v.ack >= 1 && v.ack <= TIMEOUT) begin
          r.e_mem = v.ack;
          if (!r.e_we && v.dest != 5'd0) begin
            r.e_wb = 1'b1; r.e_reg = v.dest; r.e_data = v.rdata;
          end
        end else begin
          r.e_mem = TIMEOUT;
          r.e_err = 1'b1;
        end
      end
    end
    return r;
  endfunction

  task automatic run_vec(input int idx, input vec_t v);
    int  k, memc, memfirst, wbc, wbfirst, errc, stalled;
    bit  memok, wbok, done;
    k = 0; memc = 0; memfirst = 0; wbc = 0; wbfirst = 0; errc = 0; stalled = 0;
    memok = 1'b1; wbok = 1'b1; done = 1'b0;
    wb_ready = 1'b0;
    mem_ack  = 1'b0;
    @(negedge clk);
    check($sformatf("v%0d_issue_ready", idx), 32'(in_ready), 32'd1);
    opcode = v.op; alu_result = v.res; alu_rw = v.rw; store_data = v.sd;
    dest_reg = v.dest; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    while (k < 60 && !done) begin
      @(negedge clk);
      k++;
      if (err) errc++;
      if (mem_req) begin
        memc++;
        if (memfirst == 0) memfirst = k;
        if (mem_addr !== v.e_addr || mem_we !== v.e_we || (v.e_we && mem_wdata !== v.sd))
          memok = 1'b0;
        if (memc == v.ack) begin
          mem_ack = 1'b1; mem_rdata = v.rdata;
        end
      end
      if (wb_valid) begin
        wbc++;
        if (wbfirst == 0) wbfirst = k;
        if (wb_reg !== v.e_reg || wb_data !== v.e_data) wbok = 1'b0;
        if (stalled < v.stall) begin
          wb_ready = 1'b0; stalled++;
        end else begin
          wb_ready = 1'b1;
        end
      end
      if (in_ready) begin
        done = 1'b1;
      end else begin
        @(posedge clk);
        #1 mem_ack = 1'b0;
      end
    end
    wb_ready = 1'b0;
    check($sformatf("v%0d_done", idx), 32'(done), 32'd1);
    @(negedge clk);
    if (err) errc++;
    check($sformatf("v%0d_err_pulses", idx), 32'(errc), 32'(v.e_err));
    check($sformatf("v%0d_mem_cycles", idx), 32'(memc), 32'(v.e_mem));
    check($sformatf("v%0d_mem_first", idx), 32'(memfirst), (v.e_mem > 0) ? 32'd1 : 32'd0);
    check($sformatf("v%0d_mem_fields", idx), 32'(memok), 32'd1);
    check($sformatf("v%0d_wb_cycles", idx), 32'(wbc), v.e_wb ? 32'(v.stall + 1) : 32'd0);
    check($sformatf("v%0d_wb_first", idx), 32'(wbfirst),
          !v.e_wb ? 32'd0 : (v.e_mem > 0 ? 32'(v.ack + 1) : 32'd1));
    check($sformatf("v%0d_wb_fields", idx), 32'(wbok), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[14];
    vec_t v;
    int   acc, wbn, sel;

    // Reset state
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_wb_reg", 32'(wb_reg), 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_err", 32'(err), 32'd0);

    // op, res, rw, sd, dest, ack, rdata, stall | err, mem, we, addr, wb, reg, data
    tbl[0]  = '{6'h00, 32'h0000_0007, 1'b1, 32'h0, 5'd5, 0, 32'h0, 3,
                1'b0, 0, 1'b0, 10'h0, 1'b1, 5'd5, 32'h7};
    tbl[1]  = '{OP_LW, 32'h0000_0010, 1'b0, 32'h0, 5'd8, 4, 32'hDEAD_BEEF, 0,
                1'b0, 4, 1'b0, 10'h4, 1'b1, 5'd8, 32'hDEAD_BEEF};
    tbl[2]  = '{OP_SW, 32'h0000_0024, 1'b0, 32'h1234_5678, 5'd3, 1, 32'h0, 0,
                1'b0, 1, 1'b1, 10'h9, 1'b0, 5'd0, 32'h0};
    tbl[3]  = '{OP_LW, 32'h0000_0013, 1'b0, 32'h0, 5'd8, 1, 32'h0, 0,
                1'b1, 0, 1'b0, 10'h0, 1'b0, 5'd0, 32'h0};
    tbl[4]  = '{OP_LW, 32'h0000_0040, 1'b0, 32'h0, 5'd8, 0, 32'h0, 0,
                1'b1, 16, 1'b0, 10'h10, 1'b0, 5'd0, 32'h0};
    tbl[5]  = '{OP_BEQ, 32'h0000_0100, 1'b1, 32'h0, 5'd2, 0, 32'h0, 0,
                1'b0, 0, 1'b0, 10'h0, 1'b0, 5'd0, 32'h0};
    tbl[6]  = '{OP_BNE, 32'h0000_0104, 1'b1, 32'h0, 5'd2, 0, 32'h0, 0,
                1'b0, 0, 1'b0, 10'h0, 1'b0, 5'd0, 32'h0};
    tbl[7]  = '{6'h00, 32'h0000_0099, 1'b1, 32'h0, 5'd0, 0, 32'h0, 0,
                1'b0, 0, 1'b0, 10'h0, 1'b0, 5'd0, 32'h0};
    tbl[8]  = '{6'h00, 32'h0000_0099, 1'b0, 32'h0, 5'd3, 0, 32'h0, 0,
                1'b0, 0, 1'b0, 10'h0, 1'b0, 5'd0, 32'h0};
    tbl[9]  = '{OP_LW, 32'h0000_0008, 1'b0, 32'h0, 5'd0, 2, 32'hCAFE_0001, 0,
                1'b0, 2, 1'b0, 10'h2, 1'b0, 5'd0, 32'h0};
    tbl[10] = '{OP_LW, 32'h0000_0020, 1'b0, 32'h0, 5'd17, 16, 32'h0BAD_F00D, 1,
                1'b0, 16, 1'b0, 10'h8, 1'b1, 5'd17, 32'h0BAD_F00D};
    tbl[11] = '{OP_SW, 32'h0000_0026, 1'b0, 32'hFFFF_0000, 5'd1, 1, 32'h0, 0,
                1'b1, 0, 1'b0, 10'h0, 1'b0, 5'd0, 32'h0};
    tbl[12] = '{OP_LW, 32'hFFFF_F004, 1'b0, 32'h0, 5'd31, 3, 32'h1357_9BDF, 2,
                1'b0, 3, 1'b0, 10'h001, 1'b1, 5'd31, 32'h1357_9BDF};
    tbl[13] = '{6'h3F, 32'h0000_0000, 1'b1, 32'h0, 5'd4, 0, 32'h0, 0,
                1'b0, 0, 1'b0, 10'h0, 1'b0, 5'd0, 32'h0};

    for (int i = 0; i < 14; i++) run_vec(i, tbl[i]);

    // Randomized vectors against the behavioural model
    for (int i = 0; i < 120; i++) begin
      sel = $urandom_range(0, 5);
      case (sel)
        0:       v.op = 6'h00;
        1, 2:    v.op = OP_LW;
        3:       v.op = OP_SW;
        4:       v.op = ($urandom_range(0, 1) != 0) ? OP_BEQ : OP_BNE;
        default: v.op = 6'($urandom);
      endcase
      v.res = $urandom;
      if ($urandom_range(0, 3) != 0) v.res[1:0] = 2'b00;
      v.rw    = 1'($urandom_range(0, 1));
      v.sd    = $urandom;
      v.dest  = 5'($urandom_range(0, 31));
      v.ack   = $urandom_range(0, TIMEOUT);
      v.rdata = $urandom;
      v.stall = $urandom_range(0, 2);
      v = model(v);
      run_vec(100 + i, v);
    end

    // Back-to-back R-type: one accept every other cycle
    @(negedge clk);
    wb_ready = 1'b1; opcode = 6'h00; alu_rw = 1'b1; dest_reg = 5'd3;
    alu_result = 32'h55; in_valid = 1'b1;
    acc = 0; wbn = 0;
    for (int i = 0; i < 10; i++) begin
      if (in_ready) acc++;
      if (wb_valid) wbn++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(negedge clk);
    wb_ready = 1'b0;
    check("b2b_accepts", 32'(acc), 32'd5);
    check("b2b_wb_cycles", 32'(wbn), 32'd5);

    // Asynchronous reset in MEM_WAIT, then a stray late ack
    @(negedge clk);
    opcode = OP_LW; alu_result = 32'h40; dest_reg = 5'd4; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    check("mw_req_before_rst", 32'(mem_req), 32'd1);
    #3 rst = 1'b1;
    #1;
    check("mw_rst_req_drop", 32'(mem_req), 32'd0);
    check("mw_rst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
    @(negedge clk);
    mem_ack = 1'b0;
    check("late_ack_req", 32'(mem_req), 32'd0);
    check("late_ack_wb", 32'(wb_valid), 32'd0);
    check("late_ack_err", 32'(err), 32'd0);
    check("late_ack_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    check("late_ack_wb2", 32'(wb_valid), 32'd0);

    // Asynchronous reset in WB_HOLD
    opcode = 6'h00; alu_rw = 1'b1; dest_reg = 5'd9; alu_result = 32'hAA; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("wh_valid_before_rst", 32'(wb_valid), 32'd1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("wh_rst_valid_drop", 32'(wb_valid), 32'd0);
    check("wh_rst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("wh_after_valid", 32'(wb_valid), 32'd0);
    check("wh_after_reg", 32'(wb_reg), 32'd0);
    check("wh_after_ready", 32'(in_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
